// File: rtl/rot_seq_pkg.sv
// Shared types and constants for the rotate-and-display sequencer.
package rot_seq_pkg;

  // Sequencer states, in the order a normal step walks through them.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitMult,
    StConv,
    StWaitConv,
    StShow
  } state_e;

  // The rotation table has 12 entries of 30 degrees each.
  localparam int unsigned N_ROT = 12;
  localparam int unsigned K_MAX = 11;

  // Fold an out-of-range manual index (12..15) back onto the table (0..3).
  function automatic logic [3:0] fold_k(input logic [3:0] k_in);
    return (k_in >= 4'(N_ROT)) ? (k_in - 4'(N_ROT)) : k_in;
  endfunction

  // Next rotation index for the sweep, wrapping 11 -> 0.
  function automatic logic [3:0] next_k(input logic [3:0] k_in);
    return (k_in == 4'(K_MAX)) ? 4'd0 : (k_in + 4'd1);
  endfunction

endpackage

// File: rtl/ms_dwell_timer.sv
// Counts a fixed number of 1 ms ticks after being loaded and pulses o_done on the last one.
module ms_dwell_timer #(
  parameter int unsigned DWELL_MS = 500
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  input  logic i_ce,
  output logic o_done
);

  localparam int unsigned CW = $clog2(DWELL_MS) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_MS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  // Done fires on the tick that completes the dwell, so the caller can leave in that same cycle.
  assign o_done = i_en & ~i_load & i_ce & w_last;

  // Tick counter: cleared on load, advances only on enabled ticks and parks on the last value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && i_ce && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rot_seq_ctrl.sv
// Sequencer for the rotate-and-display path: drives the rotation index, waits out the
// multiplier latency, kicks both BIN16->DEC4 converters and latches their results for display.
module rot_seq_ctrl
  import rot_seq_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3,
  parameter int unsigned CONV_TO  = 64,
  parameter int unsigned DWELL_MS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce1ms,
  input  logic       start,
  input  logic       sweep,
  input  logic       stop,
  input  logic [3:0] k_man,
  input  logic       conv_ok_re,
  input  logic       conv_ok_im,
  output logic [3:0] k,
  output logic       conv_st,
  output logic       res_we,
  output logic       busy,
  output logic       err_to
);

  localparam int unsigned MULT_W = $clog2(MULT_LAT) + 1;
  localparam int unsigned CONV_W = $clog2(CONV_TO) + 1;
  // One counter serves both the multiplier wait and the conversion timeout.
  localparam int unsigned CNT_W  = (MULT_W > CONV_W) ? MULT_W : CONV_W;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_TO - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_start_d;
  logic             r_sweep;
  logic             w_sweep_nxt;
  logic [3:0]       r_k;
  logic [3:0]       w_k_nxt;
  logic             r_err_to;
  logic             w_err_to_nxt;
  logic             r_stop;
  logic             w_stop_nxt;
  logic             r_ok_re;
  logic             w_ok_re_nxt;
  logic             r_ok_im;
  logic             w_ok_im_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_res_we;
  logic             w_res_we_nxt;
  logic             w_start_edge;
  logic             w_seen_re;
  logic             w_seen_im;
  logic             w_dwell_load;
  logic             w_dwell_done;
  logic             w_in_show;

  assign w_start_edge = start & ~r_start_d;
  assign w_in_show    = (r_state == StShow);
  // Converter done flags include the current cycle so a same-cycle pair completes at once.
  assign w_seen_re    = r_ok_re | conv_ok_re;
  assign w_seen_im    = r_ok_im | conv_ok_im;

  ms_dwell_timer #(
    .DWELL_MS(DWELL_MS)
  ) u_dwell (
    .i_clk (clk),
    .i_rst (rst),
    .i_load(w_dwell_load),
    .i_en  (w_in_show),
    .i_ce  (ce1ms),
    .o_done(w_dwell_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: start edge detector, step context, flags and the shared cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_sweep   <= 1'b0;
      r_k       <= 4'd0;
      r_err_to  <= 1'b0;
      r_stop    <= 1'b0;
      r_ok_re   <= 1'b0;
      r_ok_im   <= 1'b0;
      r_cnt     <= '0;
      r_res_we  <= 1'b0;
    end else begin
      r_start_d <= start;
      r_sweep   <= w_sweep_nxt;
      r_k       <= w_k_nxt;
      r_err_to  <= w_err_to_nxt;
      r_stop    <= w_stop_nxt;
      r_ok_re   <= w_ok_re_nxt;
      r_ok_im   <= w_ok_im_nxt;
      r_cnt     <= w_cnt_nxt;
      r_res_we  <= w_res_we_nxt;
    end
  end

  // Next-state and next-value logic for the step sequence.
  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_nxt  = r_sweep;
    w_k_nxt      = r_k;
    w_err_to_nxt = r_err_to;
    w_stop_nxt   = r_stop;
    w_ok_re_nxt  = r_ok_re;
    w_ok_im_nxt  = r_ok_im;
    w_cnt_nxt    = r_cnt;
    w_res_we_nxt = 1'b0;
    w_dwell_load = 1'b0;

    // Stop is only remembered while a step is running; an idle stop means nothing.
    if ((r_state != StIdle) && stop) begin
      w_stop_nxt = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_state_nxt  = StLoad;
          w_sweep_nxt  = sweep;
          w_k_nxt      = sweep ? 4'd0 : fold_k(k_man);
          w_err_to_nxt = 1'b0;
          w_stop_nxt   = 1'b0;
        end
      end

      StLoad: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StWaitMult;
      end

      StWaitMult: begin
        if (r_cnt == MULT_LAST) begin
          w_state_nxt = StConv;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      StConv: begin
        // Anything the converters report before their start pulse is stale.
        w_cnt_nxt   = '0;
        w_ok_re_nxt = 1'b0;
        w_ok_im_nxt = 1'b0;
        w_state_nxt = StWaitConv;
      end

      StWaitConv: begin
        w_ok_re_nxt = w_seen_re;
        w_ok_im_nxt = w_seen_im;
        if (w_seen_re && w_seen_im) begin
          w_state_nxt  = StShow;
          w_res_we_nxt = 1'b1;
          w_dwell_load = 1'b1;
        end else if (r_cnt == CONV_LAST) begin
          w_err_to_nxt = 1'b1;
          w_state_nxt  = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      StShow: begin
        if (w_dwell_done) begin
          // A stop arriving on the very last dwell tick still ends the sweep.
          if (r_sweep && !(r_stop || stop)) begin
            w_k_nxt     = next_k(r_k);
            w_state_nxt = StLoad;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign k       = r_k;
  assign conv_st = (r_state == StConv);
  assign res_we  = r_res_we;
  assign busy    = (r_state != StIdle);
  assign err_to  = r_err_to;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Scoreboard bench for rot_seq_ctrl: stimulus pushes expected conv_st/res_we events,
// a monitor pops and compares them as the DUT emits them.
module tb_rot_seq_ctrl;

  localparam int unsigned MULT_LAT = 3;
  localparam int unsigned CONV_TO  = 64;
  localparam int unsigned DWELL_MS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce1ms = 1'b0;
  logic       start = 1'b0;
  logic       sweep = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] k_man = 4'd0;
  logic       conv_ok_re = 1'b0;
  logic       conv_ok_im = 1'b0;
  logic [3:0] k;
  logic       conv_st;
  logic       res_we;
  logic       busy;
  logic       err_to;

  rot_seq_ctrl #(
    .MULT_LAT(MULT_LAT),
    .CONV_TO (CONV_TO),
    .DWELL_MS(DWELL_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce1ms     (ce1ms),
    .start     (start),
    .sweep     (sweep),
    .stop      (stop),
    .k_man     (k_man),
    .conv_ok_re(conv_ok_re),
    .conv_ok_im(conv_ok_im),
    .k         (k),
    .conv_st   (conv_st),
    .res_we    (res_we),
    .busy      (busy),
    .err_to    (err_to)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit is_res;
    int k;
    int cyc;
  } ev_t;
  ev_t sb[$];

  // 0: converters silent, 1: both at +3, 2: only Re at +3, 3: Re at +3 then Im at +5.
  int rsp_mode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input bit is_res, input int kk, input int c);
    ev_t e;
    e.is_res = is_res;
    e.k      = kk;
    e.cyc    = c;
    sb.push_back(e);
  endfunction

  task automatic check_ev(input bit is_res);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected event: %s with k=%0d at cycle %0d, none expected",
               is_res ? "res_we" : "conv_st", k, cyc);
    end else begin
      e = sb.pop_front();
      chk(is_res ? "event kind (res_we seen)" : "event kind (conv_st seen)", 32'(is_res),
          32'(e.is_res));
      chk("event k", 32'(k), 32'(e.k));
      if (e.cyc >= 0) chk("event cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (conv_st === 1'b1) check_ev(1'b0);
      if (res_we === 1'b1) check_ev(1'b1);
    end
  end

  // Converter responder
  initial begin
    forever begin
      @(negedge clk);
      if (conv_st === 1'b1) begin
        case (rsp_mode)
          1: begin
            repeat (3) @(posedge clk);
            #1 conv_ok_re = 1'b1; conv_ok_im = 1'b1;
            @(posedge clk);
            #1 conv_ok_re = 1'b0; conv_ok_im = 1'b0;
          end
          2: begin
            repeat (3) @(posedge clk);
            #1 conv_ok_re = 1'b1;
            @(posedge clk);
            #1 conv_ok_re = 1'b0;
          end
          3: begin
            repeat (3) @(posedge clk);
            #1 conv_ok_re = 1'b1;
            @(posedge clk);
            #1 conv_ok_re = 1'b0;
            @(posedge clk);
            #1 conv_ok_im = 1'b1;
            @(posedge clk);
            #1 conv_ok_im = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // 1 ms tick every 10 cycles
  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 ce1ms = 1'b1;
      @(posedge clk);
      #1 ce1ms = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic do_start(input bit sw, input logic [3:0] km, output int s);
    @(posedge clk);
    #1;
    start = 1'b1;
    sweep = sw;
    k_man = km;
    s     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        at = cyc;
        break;
      end
    end
    chk("busy drops within budget", 32'(busy), 32'd0);
  endtask

  initial begin
    int s;
    int at;
    int ticks;
    int n_st;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset k", 32'(k), 32'd0);
    chk("reset conv_st", 32'(conv_st), 32'd0);
    chk("reset res_we", 32'(res_we), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err_to", 32'(err_to), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single step k_man=5: conv_st at +5, converters at +8, res_we at +9, two-tick dwell
    rsp_mode = 1;
    do_start(1'b0, 4'd5, s);
    push(1'b0, 5, s + 5);
    push(1'b1, 5, s + 9);
    @(negedge clk);
    chk("single k after load", 32'(k), 32'd5);
    chk("single busy after load", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (res_we === 1'b1) break;
      @(negedge clk);
    end
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (ce1ms) ticks++;
      @(negedge clk);
    end
    chk("dwell ticks in SHOW", 32'(ticks), 32'd2);
    chk("single busy after dwell", 32'(busy), 32'd0);
    chk("single k held", 32'(k), 32'd5);

    // k_man=14 folds to 2; converters answer out of step; a start while busy is ignored
    rsp_mode = 3;
    do_start(1'b0, 4'd14, s);
    push(1'b0, 2, s + 5);
    push(1'b1, 2, s + 11);
    @(negedge clk);
    chk("folded k", 32'(k), 32'd2);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    k_man = 4'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(200, at);
    chk("folded k after pass", 32'(k), 32'd2);

    // Only Re converter answers: 64-cycle timeout, no res_we
    rsp_mode = 2;
    do_start(1'b0, 4'd7, s);
    push(1'b0, 7, s + 5);
    wait_idle(200, at);
    chk("timeout idle cycle", 32'(at), 32'(s + 70));
    chk("timeout err_to set", 32'(err_to), 32'd1);
    rsp_mode = 1;
    do_start(1'b0, 4'd0, s);
    push(1'b0, 0, s + 5);
    push(1'b1, 0, s + 9);
    @(negedge clk);
    chk("err_to cleared by start", 32'(err_to), 32'd0);
    wait_idle(200, at);

    // Sweep: 0..11 then 0,1; stop raised during the k=1 step of the second round
    do_start(1'b1, 4'd9, s);
    for (int i = 0; i < 14; i++) begin
      push(1'b0, i % 12, (i == 0) ? s + 5 : -1);
      push(1'b1, i % 12, -1);
    end
    n_st = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (conv_st === 1'b1) n_st++;
      if (n_st == 14) break;
    end
    chk("sweep conv_st count", 32'(n_st), 32'd14);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle(200, at);
    chk("sweep k after stop", 32'(k), 32'd1);

    // Stop during WAIT_MULT at k=4
    do_start(1'b1, 4'd0, s);
    for (int i = 0; i <= 4; i++) begin
      push(1'b0, i, -1);
      push(1'b1, i, -1);
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (k == 4'd4) break;
    end
    chk("sweep reached k=4", 32'(k), 32'd4);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle(200, at);
    chk("stopped k", 32'(k), 32'd4);

    // Reset while waiting on converters
    rsp_mode = 0;
    do_start(1'b0, 4'd3, s);
    push(1'b0, 3, s + 5);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst k", 32'(k), 32'd0);
    chk("rst conv_st", 32'(conv_st), 32'd0);
    chk("rst res_we", 32'(res_we), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err_to", 32'(err_to), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_mode = 1;
    do_start(1'b0, 4'd9, s);
    push(1'b0, 9, s + 5);
    push(1'b1, 9, s + 9);
    wait_idle(200, at);
    chk("post-reset k", 32'(k), 32'd9);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
